// File: rtl/cpwm_pkg.sv
// Shared types and widths for the carrier-PWM configuration path.
package cpwm_pkg;

    localparam int unsigned EVTCOUNT_WIDTH = 8;

    // Channel masking applied by the downstream comparator.
    typedef enum logic [1:0] {
        NO_MASK   = 2'd0,
        MASK_PWM  = 2'd1,
        MASK_INT  = 2'd2,
        MASK_CARR = 2'd3
    } _mask_mode;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic {
        INT_OFF = 1'b0,
        INT_ON  = 1'b1
    } _int_onoff;

    typedef enum logic {
        CARR_OFF = 1'b0,
        CARR_ON  = 1'b1
    } _carr_onoff;

    // Sequencer tracking of outstanding shadow data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } _seq_state;

    localparam int unsigned MASK_MODE_W = $bits(_mask_mode);

endpackage

// File: rtl/evt_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// A level first captured at edge n yields a pulse high during cycle n+2.
module evt_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_q;

    // Synchronize, delay once for history, and register the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/pwm_shadow_sequencer.sv
// Double-buffered per-channel PWM configuration: AXI writes land in shadow
// registers and move to the active set on that channel's masked-event edge.
// Optional build macro CPWM_SYNC_COMMIT_EN adds sync_all, which makes every
// pending channel commit together on channel 0's event edge.
module pwm_shadow_sequencer
    import cpwm_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned CMP_W     = 16,
    parameter bit          OVERWRITE = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [2:0]                       cfg_ch,
    input  logic [CMP_W-1:0]                 cfg_cmp,
    input  logic [EVTCOUNT_WIDTH-1:0]        cfg_evt,
    input  _mask_mode                        cfg_mode,
    input  logic [N_CH-1:0]                  maskevent,
`ifdef CPWM_SYNC_COMMIT_EN
    input  logic                             sync_all,
`endif
    output logic [N_CH*CMP_W-1:0]            act_cmp,
    output logic [N_CH*EVTCOUNT_WIDTH-1:0]   act_evt,
    output logic [N_CH*MASK_MODE_W-1:0]      act_mode,
    output logic [N_CH-1:0]                  pending,
    output logic [N_CH-1:0]                  commit_pulse,
    output logic                             all_done
);

    localparam int unsigned EVT_W  = EVTCOUNT_WIDTH;
    localparam int unsigned MODE_W = MASK_MODE_W;

    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] pending_d;
    logic [N_CH-1:0] commit_pulse_q;
    logic [N_CH-1:0] evt_edge;
    logic [N_CH-1:0] commit_en;
    logic [N_CH-1:0] wr_sel;
    logic [7:0]      pend_ext;
    logic            ch_ok;
    logic            ready_c;
    logic            wr_acc;
    _seq_state       state_q;
    _seq_state       state_d;
    logic            all_done_q;
    logic            all_done_d;

    // Out-of-range channels are accepted but never touch state.
    assign ch_ok    = (32'(cfg_ch) < N_CH);
    assign pend_ext = 8'(pending_q);

    // Write acceptance: always when overwriting, otherwise only once the
    // target channel has committed its previous shadow.
    always_comb begin
        ready_c = 1'b1;
        if (!OVERWRITE) begin
            ready_c = ~pend_ext[cfg_ch] | ~ch_ok;
        end
    end

    assign cfg_ready = ~reset & ready_c;
    assign wr_acc    = cfg_valid & cfg_ready & ch_ok;
    assign wr_sel    = wr_acc ? (N_CH'(1) << cfg_ch) : '0;

    // Commit selection; a non-pending channel ignores its edge.
    always_comb begin
`ifdef CPWM_SYNC_COMMIT_EN
        if (sync_all) begin
            commit_en = {N_CH{evt_edge[0]}} & pending_q;
        end else begin
            commit_en = evt_edge & pending_q;
        end
`else
        commit_en = evt_edge & pending_q;
`endif
    end

    // A commit and a write in the same cycle leave the channel pending.
    assign pending_d = (pending_q & ~commit_en) | wr_sel;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CMP_W-1:0] shd_cmp_q;
        logic [EVT_W-1:0] shd_evt_q;
        _mask_mode        shd_mode_q;
        logic [CMP_W-1:0] act_cmp_q;
        logic [EVT_W-1:0] act_evt_q;
        _mask_mode        act_mode_q;

        evt_edge_sync u_evt_edge_sync (
            .clk     (clk),
            .reset   (reset),
            .async_i (maskevent[i]),
            .edge_o  (evt_edge[i])
        );

        // Shadow captures writes; active takes the pre-write shadow on commit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shd_cmp_q  <= '0;
                shd_evt_q  <= '0;
                shd_mode_q <= NO_MASK;
                act_cmp_q  <= '0;
                act_evt_q  <= '0;
                act_mode_q <= NO_MASK;
            end else begin
                if (wr_sel[i]) begin
                    shd_cmp_q  <= cfg_cmp;
                    shd_evt_q  <= cfg_evt;
                    shd_mode_q <= cfg_mode;
                end
                if (commit_en[i]) begin
                    act_cmp_q  <= shd_cmp_q;
                    act_evt_q  <= shd_evt_q;
                    act_mode_q <= shd_mode_q;
                end
            end
        end

        assign act_cmp[i*CMP_W +: CMP_W]   = act_cmp_q;
        assign act_evt[i*EVT_W +: EVT_W]   = act_evt_q;
        assign act_mode[i*MODE_W +: MODE_W] = act_mode_q;
    end

    // Pending flags and the one-cycle commit strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            commit_pulse_q <= '0;
        end else begin
            pending_q      <= pending_d;
            commit_pulse_q <= commit_en;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            all_done_q <= all_done_d;
        end
    end

    // Next state: announce all_done once the pending set has fully drained.
    always_comb begin
        state_d    = state_q;
        all_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if ((pending_q == '0) && !wr_acc) begin
                    state_d    = DRAIN;
                    all_done_d = 1'b1;
                end
            end
            DRAIN: begin
                state_d = wr_acc ? ARMED : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pending      = pending_q;
    assign commit_pulse = commit_pulse_q;
    assign all_done     = all_done_q;

endmodule
